// File: rtl/instruction_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit_pkg
//   Shared definitions for the fetch unit and its users: opcode encodings,
//   instruction field positions, fetch FSM states and a small decode helper
//   that classifies the control-flow opcodes resolved inside the fetch unit.
// ---------------------------------------------------------------------------
package instruction_fetch_unit_pkg;

    // Instruction field positions: [27:24] opcode, [23:16] dst/target, [15:0] imm
    localparam int INSTR_OPC_MSB = 27;
    localparam int INSTR_OPC_LSB = 24;
    localparam int INSTR_TGT_MSB = 23;
    localparam int INSTR_TGT_LSB = 16;

    // Opcode encodings
    localparam logic [3:0] OPC_NOP  = 4'h0;
    localparam logic [3:0] OPC_ADD  = 4'h1;
    localparam logic [3:0] OPC_SUB  = 4'h2;
    localparam logic [3:0] OPC_SHL  = 4'h3;
    localparam logic [3:0] OPC_STO  = 4'h5;
    localparam logic [3:0] OPC_BLE  = 4'h8;
    localparam logic [3:0] OPC_JMP  = 4'hC;
    localparam logic [3:0] OPC_CALL = 4'hD;
    localparam logic [3:0] OPC_RET  = 4'hE;

    // Fetch FSM states
    typedef enum logic {
        FETCH_RUN  = 1'b0,
        FETCH_HALT = 1'b1
    } fetch_state_e;

    // Control-flow classes consumed by the fetch unit
    typedef enum logic [1:0] {
        CF_NONE = 2'd0,
        CF_JMP  = 2'd1,
        CF_CALL = 2'd2,
        CF_RET  = 2'd3
    } ctrl_kind_e;

    function automatic ctrl_kind_e decode_ctrl(input logic [3:0] opc);
        ctrl_kind_e kind;
        case (opc)
            OPC_JMP:  kind = CF_JMP;
            OPC_CALL: kind = CF_CALL;
            OPC_RET:  kind = CF_RET;
            default:  kind = CF_NONE;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_return_stack.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit_return_stack
//   Return-address stack for CALL/RET, depth-parameterised (power of two).
//   sp counts entries: push writes slot sp then increments, pop reads slot
//   sp-1 then decrements. Slots are addressed by the low bits of sp, so
//   overflow overwrites the oldest entry and underflow yields a stale one.
//   The extra sp bit lets full (sp == DEPTH) be distinguished from empty.
// Ports
//   clk, rst    clock, synchronous active-high reset (clears sp only)
//   push, pop   one-cycle requests, never asserted together
//   push_data   return address to store
//   pop_data    entry at sp-1, combinational
//   sp          current entry count
//   full, empty sp == DEPTH / sp == 0
// ---------------------------------------------------------------------------
module instruction_fetch_unit_return_stack #(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 8,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int SP_W  = IDX_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] pop_data,
    output logic [SP_W-1:0]   sp,
    output logic              full,
    output logic              empty
);

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [SP_W-1:0]   sp_q;
    logic [SP_W-1:0]   sp_dec;

    assign sp_dec = sp_q - SP_W'(1);

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q <= '0;
        end else if (push) begin
            sp_q <= sp_q + SP_W'(1);
        end else if (pop) begin
            sp_q <= sp_dec;
        end
    end

    // NOTE: the storage array has no reset; sp alone defines which entries
    // are live, and leaving the array unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[sp_q[IDX_W-1:0]] <= push_data;
        end
    end

    assign pop_data = mem[sp_dec[IDX_W-1:0]];
    assign sp       = sp_q;
    assign full     = (sp_q == SP_W'(DEPTH));
    assign empty    = (sp_q == '0);

endmodule

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//   Reader side of the program ROM. Owns the PC, drives the ROM address,
//   registers each fetched word towards execute, and resolves JMP/CALL/RET
//   locally with a return-address stack. Execute may redirect (BLE taken)
//   or stall. Control-flow words are consumed here and never forwarded.
//   Priority per edge: Reset > iBranchTaken > iStall > local decode.
// Configuration
//   FETCH_STACK_CHECK_EN  when defined, a push on a full stack or a pop on
//                         an empty one sets sticky oStackErr and parks the
//                         unit in HALT until Reset. When undefined the stack
//                         wraps silently and oStackErr is tied low.
// Ports
//   Clock          single clock, rising edge
//   Reset          synchronous, active-high
//   oAddress       ROM address (the PC register)
//   iInstruction   ROM data for oAddress, same cycle
//   iStall         execute not ready: hold all state
//   iBranchTaken   execute redirect pulse
//   iBranchTarget  redirect target, zero-extended
//   oInstruction   registered instruction to execute
//   oValid         oInstruction is meaningful
//   oStackErr      sticky stack fault
// ---------------------------------------------------------------------------
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int INSTR_W     = 28,
    parameter int STACK_DEPTH = 8
) (
    input  logic               Clock,
    input  logic               Reset,
    output logic [ADDR_W-1:0]  oAddress,
    input  logic [INSTR_W-1:0] iInstruction,
    input  logic               iStall,
    input  logic               iBranchTaken,
    input  logic [7:0]         iBranchTarget,
    output logic [INSTR_W-1:0] oInstruction,
    output logic               oValid,
    output logic               oStackErr
);

    localparam int SP_W = $clog2(STACK_DEPTH) + 1;

    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_next;
    logic [ADDR_W-1:0]  pc_inc;
    logic [ADDR_W-1:0]  jump_target;
    logic [INSTR_W-1:0] instr_q;
    logic [INSTR_W-1:0] instr_next;
    logic               valid_q;
    logic               valid_next;
    ctrl_kind_e         kind;

    logic               push;
    logic               pop;
    logic [ADDR_W-1:0]  ret_addr;
    logic [SP_W-1:0]    stack_sp;
    logic               stack_full;
    logic               stack_empty;
    logic               stack_fault;
    logic               run;
    logic               unused_stack;

    assign kind        = decode_ctrl(iInstruction[INSTR_OPC_MSB:INSTR_OPC_LSB]);
    assign jump_target = ADDR_W'(iInstruction[INSTR_TGT_MSB:INSTR_TGT_LSB]);
    assign pc_inc      = pc + ADDR_W'(1);

    instruction_fetch_unit_return_stack #(
        .ADDR_W (ADDR_W),
        .DEPTH  (STACK_DEPTH)
    ) u_stack (
        .clk       (Clock),
        .rst       (Reset),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .pop_data  (ret_addr),
        .sp        (stack_sp),
        .full      (stack_full),
        .empty     (stack_empty)
    );

`ifdef FETCH_STACK_CHECK_EN
    fetch_state_e state;
    fetch_state_e state_next;
    logic         halt_req;
    logic         err_q;

    assign stack_fault = (kind == CF_CALL && stack_full) ||
                         (kind == CF_RET  && stack_empty);
    // A fault only counts when decode would actually act on the word.
    assign halt_req    = run && !iBranchTaken && !iStall && stack_fault;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= FETCH_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (state == FETCH_RUN && halt_req) begin
            state_next = FETCH_HALT;
        end
    end

    always_comb begin
        run = (state == FETCH_RUN);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            err_q <= 1'b0;
        end else if (halt_req) begin
            err_q <= 1'b1;
        end
    end

    assign oStackErr    = err_q;
    assign unused_stack = ^stack_sp;
`else
    assign run          = 1'b1;
    assign stack_fault  = 1'b0;
    assign oStackErr    = 1'b0;
    assign unused_stack = ^{stack_sp, stack_full, stack_empty};
`endif

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no branch
        // can leave one unassigned and infer a latch.
        pc_next    = pc;
        instr_next = instr_q;
        valid_next = valid_q;
        push       = 1'b0;
        pop        = 1'b0;
        if (!run) begin
            valid_next = 1'b0;
        end else if (iBranchTaken) begin
            // Redirect squashes the word fetched this cycle; stack untouched.
            pc_next    = ADDR_W'(iBranchTarget);
            valid_next = 1'b0;
        end else if (!iStall) begin
            if (stack_fault) begin
                valid_next = 1'b0;
            end else begin
                case (kind)
                    CF_JMP: begin
                        pc_next    = jump_target;
                        valid_next = 1'b0;
                    end
                    CF_CALL: begin
                        push       = 1'b1;
                        pc_next    = jump_target;
                        valid_next = 1'b0;
                    end
                    CF_RET: begin
                        pop        = 1'b1;
                        pc_next    = ret_addr;
                        valid_next = 1'b0;
                    end
                    default: begin
                        instr_next = iInstruction;
                        valid_next = 1'b1;
                        pc_next    = pc_inc;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            pc      <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else begin
            pc      <= pc_next;
            instr_q <= instr_next;
            valid_q <= valid_next;
        end
    end

    assign oAddress     = pc;
    assign oInstruction = instr_q;
    assign oValid       = valid_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_unit
//   Directed bench for instruction_fetch_unit. A stimulus process walks a
//   hand-written program and pushes each word it expects to reach execute
//   into a queue; a monitor pops and compares whenever a fresh word is
//   presented. A second instance with an 8-bit PC exercises PC wrap-around.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_unit;
    import instruction_fetch_unit_pkg::*;

    localparam int ADDR_W      = 16;
    localparam int INSTR_W     = 28;
    localparam int STACK_DEPTH = 8;

    logic               Clock = 1'b0;
    logic               Reset = 1'b1;
    logic [ADDR_W-1:0]  oAddress;
    logic [INSTR_W-1:0] iInstruction;
    logic               iStall = 1'b0;
    logic               iBranchTaken = 1'b0;
    logic [7:0]         iBranchTarget = 8'h00;
    logic [INSTR_W-1:0] oInstruction;
    logic               oValid;
    logic               oStackErr;

    logic [7:0]         w_addr;
    logic [INSTR_W-1:0] w_instr;
    logic               w_br = 1'b0;
    logic [7:0]         w_tgt = 8'h00;
    logic [INSTR_W-1:0] w_out;
    logic               w_valid;
    logic               w_err;

    logic [INSTR_W-1:0] rom [256];
    logic [INSTR_W-1:0] exp_q [$];
    logic [INSTR_W-1:0] exp_word;
    logic               last_stall = 1'b0;
    int                 total = 0;
    int                 bad = 0;
    int                 ret_seq [9];

    always #5 Clock = ~Clock;

    assign iInstruction = (oAddress[15:8] == 8'h00) ? rom[oAddress[7:0]]
                                                    : {OPC_NOP, 24'h000000};
    assign w_instr      = {OPC_ADD, 8'h5A, 8'h00, w_addr};

    instruction_fetch_unit #(
        .ADDR_W      (ADDR_W),
        .INSTR_W     (INSTR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .oAddress      (oAddress),
        .iInstruction  (iInstruction),
        .iStall        (iStall),
        .iBranchTaken  (iBranchTaken),
        .iBranchTarget (iBranchTarget),
        .oInstruction  (oInstruction),
        .oValid        (oValid),
        .oStackErr     (oStackErr)
    );

    instruction_fetch_unit #(
        .ADDR_W      (8),
        .INSTR_W     (INSTR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) dut_wrap (
        .Clock         (Clock),
        .Reset         (Reset),
        .oAddress      (w_addr),
        .iInstruction  (w_instr),
        .iStall        (1'b0),
        .iBranchTaken  (w_br),
        .iBranchTarget (w_tgt),
        .oInstruction  (w_out),
        .oValid        (w_valid),
        .oStackErr     (w_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(negedge Clock);
    endtask

    task automatic expect_word(input int addr);
        exp_q.push_back(rom[addr]);
    endtask

    task automatic check_fetch(input string name, input int addr, input logic valid);
        check({name, "_addr"}, 32'(oAddress), 32'(addr));
        check({name, "_valid"}, 32'(oValid), 32'(valid));
    endtask

    task automatic check_sp(input string name, input int entries);
        check({name, "_sp"}, 32'(int'(dut.u_stack.sp) % STACK_DEPTH),
              32'(entries % STACK_DEPTH));
    endtask

    // Monitor: a word counts once, on the first cycle after a non-stalled edge.
    always @(posedge Clock) last_stall <= iStall;

    always @(negedge Clock) begin
        if (oValid === 1'b1 && !last_stall) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word: got %h, want no word (t=%0t)", oInstruction, $time);
            end else begin
                exp_word = exp_q.pop_front();
                check("sb_word", 32'(oInstruction), 32'(exp_word));
            end
        end
    end

    initial begin
        for (int a = 0; a < 256; a++) begin
            rom[a] = {OPC_ADD, 8'(a), 16'hA000 | 16'(a)};
        end
        rom[0] = {OPC_NOP,  8'h00, 16'h1111};
        rom[1] = {OPC_STO,  8'h01, 16'h0101};
        rom[2] = {OPC_STO,  8'h02, 16'h0202};
        rom[4] = {OPC_CALL, 8'h07, 16'h0000};
        rom[5] = {OPC_ADD,  8'h05, 16'h0505};
        rom[7] = {OPC_SHL,  8'h07, 16'h0007};
        rom[8] = {OPC_RET,  8'h00, 16'h0000};
        // Nine nested calls: CALL at 0x40+2k targets the next site, RET at 0x41+2k.
        for (int k = 0; k < 9; k++) begin
            rom[8'h40 + 2*k] = {OPC_CALL, 8'(8'h42 + 2*k), 16'h0000};
            rom[8'h41 + 2*k] = {OPC_RET,  8'h00, 16'h0000};
        end
        rom[8'h52] = {OPC_RET, 8'h00, 16'h0000};
        ret_seq = '{32'h51, 32'h4F, 32'h4D, 32'h4B, 32'h49, 32'h47, 32'h45, 32'h43, 32'h51};

        // Reset held for two cycles
        tick();
        tick();
        check_fetch("reset", 0, 1'b0);
        check("reset_instr", 32'(oInstruction), 32'h0);
        check("reset_err", 32'(oStackErr), 32'h0);
        check_sp("reset", 0);
        Reset = 1'b0;

        // Straight-line fetch 0,1,2,3
        expect_word(0);
        tick(); check_fetch("seq1", 1, 1'b1);
        expect_word(1);
        tick(); check_fetch("seq2", 2, 1'b1);
        expect_word(2);
        tick(); check_fetch("seq3", 3, 1'b1);
        expect_word(3);
        tick(); check_fetch("seq4", 4, 1'b1);

        // CALL 7 / SHL / RET back to 5
        tick(); check_fetch("call", 7, 1'b0); check_sp("call", 1);
        expect_word(7);
        tick(); check_fetch("shl", 8, 1'b1);
        tick(); check_fetch("ret", 5, 1'b0); check_sp("ret", 0);

        // Stall three cycles at address 5 (no word pending)
        iStall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_fetch("stall5", 5, 1'b0);
            check("stall5_instr", 32'(oInstruction), 32'(rom[7]));
        end
        iStall = 1'b0;
        expect_word(5);
        tick(); check_fetch("resume6", 6, 1'b1);

        // Stall while a valid word is held
        iStall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_fetch("stall6", 6, 1'b1);
            check("stall6_instr", 32'(oInstruction), 32'(rom[5]));
        end
        iStall = 1'b0;
        expect_word(6);
        tick(); check_fetch("resume7", 7, 1'b1);

        // Redirect squashes the fetched word, then branch overrides stall
        iBranchTaken = 1'b1; iBranchTarget = 8'd13;
        tick(); check_fetch("br13", 13, 1'b0);
        iBranchTarget = 8'd10; iStall = 1'b1;
        tick(); check_fetch("br_stall", 10, 1'b0);
        iBranchTaken = 1'b0; iStall = 1'b0;
        expect_word(10);
        tick(); check_fetch("after_br1", 11, 1'b1);
        expect_word(11);
        tick(); check_fetch("after_br2", 12, 1'b1);

        // Branch together with CALL / RET: branch wins, no push or pop
        iBranchTaken = 1'b1; iBranchTarget = 8'd4;
        tick(); check_fetch("to_call", 4, 1'b0);
        iBranchTarget = 8'd20;
        tick(); check_fetch("br_call", 20, 1'b0); check_sp("br_call", 0);
        iBranchTaken = 1'b0;
        expect_word(20);
        tick(); check_fetch("after_bc", 21, 1'b1);
        iBranchTaken = 1'b1; iBranchTarget = 8'd8;
        tick(); check_fetch("to_ret", 8, 1'b0);
        iBranchTarget = 8'd30;
        tick(); check_fetch("br_ret", 30, 1'b0); check_sp("br_ret", 0);
        iBranchTarget = 8'h40;
        tick(); check_fetch("to_nest", 32'h40, 1'b0);
        iBranchTaken = 1'b0;

`ifdef FETCH_STACK_CHECK_EN
        for (int i = 1; i <= 8; i++) begin
            tick(); check_fetch("nest_call", 32'h40 + 2*i, 1'b0); check_sp("nest_call", i);
        end
        tick();
        check_fetch("halt", 32'h50, 1'b0);
        check("halt_err", 32'(oStackErr), 32'h1);
        iBranchTaken = 1'b1; iBranchTarget = 8'h10;
        tick();
        check_fetch("halt_br", 32'h50, 1'b0);
        check("halt_err2", 32'(oStackErr), 32'h1);
        iBranchTaken = 1'b0;
`else
        for (int i = 1; i <= 9; i++) begin
            tick(); check_fetch("nest_call", 32'h40 + 2*i, 1'b0); check_sp("nest_call", i);
        end
        for (int j = 0; j < 9; j++) begin
            tick(); check_fetch("nest_ret", ret_seq[j], 1'b0); check_sp("nest_ret", 8 - j);
        end
        check("nest_err", 32'(oStackErr), 32'h0);
`endif

        // Reset discards the stack and restarts at 0
        Reset = 1'b1;
        tick();
        check_fetch("rst2", 0, 1'b0);
        check("rst2_err", 32'(oStackErr), 32'h0);
        check("rst2_instr", 32'(oInstruction), 32'h0);
        check_sp("rst2", 0);

        // PC wrap on the 8-bit instance; main instance held in stall
        Reset = 1'b0; iStall = 1'b1;
        w_br = 1'b1; w_tgt = 8'hFF;
        tick();
        check("wrap_ff", 32'(w_addr), 32'hFF);
        check_fetch("main_hold", 0, 1'b0);
        w_br = 1'b0;
        tick();
        check("wrap_zero", 32'(w_addr), 32'h00);
        check("wrap_valid", 32'(w_valid), 32'h1);
        check("wrap_word", 32'(w_out), {4'h0, OPC_ADD, 24'h5A00FF});
        tick();
        check("wrap_one", 32'(w_addr), 32'h01);
        check("wrap_word2", 32'(w_out), {4'h0, OPC_ADD, 24'h5A0000});

        check("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
